// File: rtl/adder0_pkg.sv
// Shared constants for the adder0 ripple-carry adder.
package adder0_pkg;
  localparam int unsigned ADDER0_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell; chained to form the ripple adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/adder0.sv
// Ripple-carry adder computing {Cout, Sum} = x + y + Cin, optionally registered.
module adder0
  import adder0_pkg::*;
#(
  parameter int unsigned WIDTH   = ADDER0_DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = Cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder_cell u_cell (
      .a  (x[gi]),
      .b  (y[gi]),
      .ci (w_carry[gi]),
      .s  (w_sum[gi]),
      .co (w_carry[gi+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum  <= '0;
        r_cout <= 1'b0;
      end else begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
  end else begin : g_comb
    // Clock and reset are intentionally ignored in the combinational build.
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst};

    assign Sum  = w_sum;
    assign Cout = w_carry[WIDTH];
  end
endmodule

// File: tb/tb_adder0.sv
// Self-checking bench for adder0: registered 1-bit, registered 4-bit and combinational builds.
module tb_adder0;
  logic       clk = 1'b0;
  logic       rst;
  logic       x1, y1, c1, cout1, sum1;
  logic [3:0] x4, y4, sum4;
  logic       c4, cout4;
  logic       xc, yc, cc, rstc, coutc, sumc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder0 #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .Cin(c1), .Cout(cout1), .Sum(sum1)
  );
  adder0 #(.WIDTH(4), .REG_OUT(1'b1)) u4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .Cin(c4), .Cout(cout4), .Sum(sum4)
  );
  adder0 #(.WIDTH(1), .REG_OUT(1'b0)) uc (
    .clk(clk), .rst(rstc), .x(xc), .y(yc), .Cin(cc), .Cout(coutc), .Sum(sumc)
  );

  typedef struct {
    logic       x;
    logic       y;
    logic       cin;
    logic [1:0] exp;
  } vec1_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       cin;
    logic [4:0] exp;
  } vec4_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  vec1_t tbl1[8];
  vec4_t tbl4[3];

  initial begin
    logic [4:0] prev4;
    logic [1:0] prev1;

    tbl1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tbl1[2] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl1[3] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tbl1[4] = '{1'b1, 1'b1, 1'b1, 2'b11};
    tbl1[5] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl1[6] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tbl1[7] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tbl4[0] = '{4'hF, 4'h0, 1'b1, 5'h10};
    tbl4[1] = '{4'h7, 4'h8, 1'b0, 5'h0F};
    tbl4[2] = '{4'hF, 4'hF, 1'b1, 5'h1F};

    rst = 1'b1; x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
    x4 = 4'hF; y4 = 4'hF; c4 = 1'b1;
    xc = 1'b0; yc = 1'b0; cc = 1'b0; rstc = 1'b0;

    // Reset held for two edges with all-ones inputs
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_w1", {6'b0, cout1, sum1}, 8'h00);
      chk("reset_w4", {3'b0, cout4, sum4}, 8'h00);
    end
    rst = 1'b0;
    tick();
    chk("post_reset_w1", {6'b0, cout1, sum1}, 8'h03);
    chk("post_reset_w4", {3'b0, cout4, sum4}, 8'h1F);

    // Exhaustive 1-bit sweep, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      x1 = tbl1[i].x; y1 = tbl1[i].y; c1 = tbl1[i].cin;
      tick();
      chk($sformatf("sweep_w1[%0d]", i), {6'b0, cout1, sum1}, {6'b0, tbl1[i].exp});
    end

    // Latency: output must not move before the capturing edge
    x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    tick();
    chk("lat_base", {6'b0, cout1, sum1}, 8'h00);
    @(negedge clk);
    x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
    #3;
    chk("lat_before_edge", {6'b0, cout1, sum1}, 8'h00);
    tick();
    chk("lat_after_edge", {6'b0, cout1, sum1}, 8'h03);

    // Mid-stream reset discards the in-flight result
    x1 = 1'b1; y1 = 1'b1; c1 = 1'b0;
    tick();
    chk("stream_pre", {6'b0, cout1, sum1}, 8'h02);
    rst = 1'b1;
    tick();
    chk("stream_rst", {6'b0, cout1, sum1}, 8'h00);
    rst = 1'b0;
    tick();
    chk("stream_resume", {6'b0, cout1, sum1}, 8'h02);

    // 4-bit carry-chain corner cases
    for (int i = 0; i < 3; i++) begin
      x4 = tbl4[i].x; y4 = tbl4[i].y; c4 = tbl4[i].cin;
      tick();
      chk($sformatf("chain_w4[%0d]", i), {3'b0, cout4, sum4}, {3'b0, tbl4[i].exp});
    end

    // Randomized streaming: new operands every cycle, compared one cycle later
    x4 = 4'($urandom); y4 = 4'($urandom); c4 = 1'($urandom);
    x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
    prev4 = ref4(x4, y4, c4);
    prev1 = ref1(x1, y1, c1);
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("rand_w4", {3'b0, cout4, sum4}, {3'b0, prev4});
      chk("rand_w1", {6'b0, cout1, sum1}, {6'b0, prev1});
      x4 = 4'($urandom); y4 = 4'($urandom); c4 = 1'($urandom);
      x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
      prev4 = ref4(x4, y4, c4);
      prev1 = ref1(x1, y1, c1);
    end

    // Combinational build: zero latency, reset ignored
    xc = 1'b1; yc = 1'b0; cc = 1'b1;
    #1;
    chk("comb_101", {6'b0, coutc, sumc}, 8'h02);
    rstc = 1'b1;
    #1;
    chk("comb_rst_hi", {6'b0, coutc, sumc}, 8'h02);
    rstc = 1'b0;
    #1;
    chk("comb_rst_lo", {6'b0, coutc, sumc}, 8'h02);
    for (int i = 0; i < 8; i++) begin
      xc = tbl1[i].x; yc = tbl1[i].y; cc = tbl1[i].cin;
      rstc = 1'($urandom);
      #1;
      chk($sformatf("comb_sweep[%0d]", i), {6'b0, coutc, sumc}, {6'b0, ref1(xc, yc, cc)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder0.md
Name: adder0

Overview:
- Full adder with registered outputs: adds operands x, y and carry-in Cin; produces Sum and Cout.
- Default WIDTH=1 gives a single-bit full adder. Wider settings give a ripple-carry adder built from per-bit full-adder cells.
- Used as a leaf arithmetic block. The result is captured on the rising clock edge so downstream logic sees a clean, registered value.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range is 1 or more.
- REG_OUT, 1, 1 = outputs registered with 1-cycle latency; 0 = purely combinational outputs, and clk/rst are ignored.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- Cin  input  1  carry-in, added at bit 0.
- Cout  output  1  carry-out of the MSB.
- Sum  output  WIDTH  sum bits.

Behaviour:
- Arithmetic: {Cout, Sum} = x + y + Cin, computed at WIDTH+1 bits with no truncation of the carry. Operands are unsigned.
- Per-bit cell: s = a ^ b ^ ci and co = (a & b) | (ci & (a ^ b)). Bit i's carry-out feeds bit i+1's carry-in. Cin feeds bit 0; the carry-out of bit WIDTH-1 drives Cout.
- REG_OUT=1:
  - On each rising clk edge with rst=0, Sum and Cout load the combinational result of the x, y, Cin values present before that edge.
  - Latency is exactly 1 cycle.
  - No enable or handshake: the block accepts a new operand set every cycle, giving throughput of 1 per cycle.
- Reset (REG_OUT=1):
  - rst=1 sampled at a rising edge sets Sum to all zeros and Cout to 0.
  - Reset has priority over the data captured on the same edge.
  - Assertion mid-stream discards the in-flight result.
  - On the first edge after rst deasserts, the outputs load the result of the inputs present at that edge.
  - Before the first reset edge, outputs are undefined (X in simulation).
- REG_OUT=0: Sum and Cout follow the inputs combinationally with zero latency; rst has no effect.
- Boundary cases:
  - All inputs zero gives Sum=0, Cout=0.
  - All ones (x=y=2^WIDTH-1, Cin=1) gives Sum=2^WIDTH-1, Cout=1.
  - A carry chain must propagate end to end within one cycle: x=2^WIDTH-1, y=0, Cin=1 gives Sum=0, Cout=1.
- Inputs are sampled only at clock edges when REG_OUT=1. Glitches between edges have no effect.
- No latches; no internal state other than the output registers.

Decomposition:
- Shared package adder0_pkg holds a constant for the default width (ADDER0_DEFAULT_WIDTH = 1). No typedefs are required beyond this.
- Sub-module full_adder_cell: a 1-bit combinational cell with ports a, b, ci, s, co. It is instantiated WIDTH times in a generate loop to form the ripple chain.
- The top level holds the generate loop, the carry vector of WIDTH+1 bits, and the output registers, gated by REG_OUT.

Test Plan:
- Reset, WIDTH=1, REG_OUT=1: hold rst=1 for 2 cycles with x=1, y=1, Cin=1 -> {Cout,Sum}=2'b00 during reset. After rst drops, the next edge gives {Cout,Sum}=2'b11.
- Exhaustive WIDTH=1 sweep, one vector per cycle, checked 1 cycle later:
  - (0,0,0) -> 00; (0,0,1) -> 01; (0,1,1) -> 10; (1,0,1) -> 10.
  - (1,1,1) -> 11; (0,1,0) -> 01; (1,0,0) -> 01; (1,1,0) -> 10.
  - Also (0,1,0)/(1,0,0) after carry cases, confirming no state carries between cycles.
- Latency: change the inputs from (0,0,0) to (1,1,1) just before edge N -> outputs read 00 until edge N and 11 after edge N, never earlier.
- Mid-stream reset: stream (1,1,0) and assert rst for one edge -> outputs are 00 on that edge, then resume with 10 on the following edge.
- WIDTH=4 carry chain: x=4'hF, y=4'h0, Cin=1 -> Sum=4'h0, Cout=1. x=4'h7, y=4'h8, Cin=0 -> Sum=4'hF, Cout=0. x=y=4'hF, Cin=1 -> Sum=4'hF, Cout=1.
- REG_OUT=0, WIDTH=1: apply (1,0,1) -> Cout=1, Sum=0 in the same timestep; toggling rst leaves the outputs unchanged.
